// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: fetch (A) vs load/store (B), one transaction at a time with a watchdog.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants under contention; otherwise B has fixed priority.
module mem_port_arbiter #(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic [DATA_W-1:0] addr_a,
   input  logic              req_b,
   input  logic [DATA_W-1:0] addr_b,
   input  logic              we_b,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              done_a,
   output logic              done_b,
   output logic              err_a,
   output logic              err_b,
   output logic [DATA_W-1:0] rdata,
   output logic              sel_mux,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wd_cnt;
   logic             last_b;
   logic             pick_a;
   logic             grant_a, grant_b;
   logic             timeout;

   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_a = last_b;
`else
      pick_a = 1'b0;
`endif
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      state_nxt = state;
      timeout   = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
      case (state)
         IDLE: begin
            // pick_a only matters when both requesters are asking
            if (req_a && (!req_b || pick_a)) begin
               grant_a   = 1'b1;
               state_nxt = BUSY_A;
            end else if (req_b) begin
               grant_b   = 1'b1;
               state_nxt = BUSY_B;
            end
         end
         BUSY_A, BUSY_B: if (mem_ack || timeout) state_nxt = RESP;
         RESP:           state_nxt = IDLE;
         default:        state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_a    <= 1'b0;
         done_b    <= 1'b0;
         err_a     <= 1'b0;
         err_b     <= 1'b0;
         rdata     <= '0;
         sel_mux   <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wd_cnt    <= '0;
         last_b    <= 1'b1;
      end else begin
         done_a <= 1'b0;
         done_b <= 1'b0;
         err_a  <= 1'b0;
         err_b  <= 1'b0;
         if (grant_a || grant_b) begin
            mem_req  <= 1'b1;
            sel_mux  <= grant_b;
            mem_addr <= grant_b ? addr_b : addr_a;
            mem_we   <= grant_b & we_b;
            if (grant_b) mem_wdata <= wdata_b;
            wd_cnt   <= '0;
            last_b   <= grant_b;
         end else if (state == BUSY_A || state == BUSY_B) begin
            // an ack arriving in the final watchdog cycle still completes normally
            if (mem_ack) begin
               rdata   <= mem_rdata;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               done_a  <= (state == BUSY_A);
               done_b  <= (state == BUSY_B);
            end else if (timeout) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               err_a   <= (state == BUSY_A);
               err_b   <= (state == BUSY_B);
            end else begin
               wd_cnt <= wd_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory responder checks grants, a monitor checks done/err pulses.
module tb_mem_port_arbiter;
   localparam int DATA_W      = 32;
   localparam int TIMEOUT_CYC = 16;
   localparam int CNT_W       = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_a, req_b, we_b;
   logic [DATA_W-1:0] addr_a, addr_b, wdata_b;
   logic              done_a, done_b, err_a, err_b;
   logic [DATA_W-1:0] rdata, mem_addr, mem_wdata;
   logic              sel_mux, mem_req, mem_we, busy;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   // responder state
   logic              ack_r = 1'b0;
   logic [DATA_W-1:0] rdata_r = '0;
   logic              stray_ack = 1'b0;
   logic [DATA_W-1:0] stray_data = '0;
   int                ack_lat = 0;
   logic [DATA_W-1:0] resp_data = '0;
   logic              req_prev = 1'b0;
   int                req_len = 0;

   // scoreboard
   logic [DATA_W+3:0]   exp_q[$];
   logic [2*DATA_W+1:0] grant_q[$];
   logic [DATA_W-1:0]   model_rdata = '0;
   int                  n_checks = 0;
   int                  n_fail = 0;

   assign mem_ack   = ack_r | stray_ack;
   assign mem_rdata = stray_ack ? stray_data : rdata_r;

   mem_port_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .addr_a(addr_a),
      .req_b(req_b), .addr_b(addr_b), .we_b(we_b), .wdata_b(wdata_b),
      .done_a(done_a), .done_b(done_b), .err_a(err_a), .err_b(err_b),
      .rdata(rdata), .sel_mux(sel_mux),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_flags"}, 64'({done_a, done_b, err_a, err_b, sel_mux, mem_req, mem_we, busy}), 64'd0);
      check_eq({tag, "_rdata"}, 64'(rdata), 64'd0);
      check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
   endtask

   // memory model: checks each grant, acks after ack_lat cycles (never if negative)
   always @(negedge clk) begin
      ack_r = 1'b0;
      if (rst) begin
         req_prev = 1'b0;
         req_len  = 0;
      end else begin
         if (mem_req) begin
            if (!req_prev) begin
               req_len = 0;
               if (grant_q.size() == 0) check_eq("grant_unexpected", 64'd1, 64'd0);
               else begin
                  logic [2*DATA_W+1:0] g;
                  g = grant_q.pop_front();
                  check_eq("grant_sel", 64'(sel_mux), 64'(g[2*DATA_W+1]));
                  check_eq("grant_we", 64'(mem_we), 64'(g[2*DATA_W]));
                  check_eq("grant_addr", 64'(mem_addr), 64'(g[2*DATA_W-1:DATA_W]));
                  if (g[2*DATA_W+1]) check_eq("grant_wdata", 64'(mem_wdata), 64'(g[DATA_W-1:0]));
               end
            end
            if (ack_lat >= 0 && req_len == ack_lat) begin
               ack_r   = 1'b1;
               rdata_r = resp_data;
            end
            req_len++;
         end else if (req_prev) begin
            check_eq("mem_req_len", 64'(req_len), 64'(ack_lat < 0 ? TIMEOUT_CYC : ack_lat + 1));
         end
         req_prev = mem_req;
      end
   end

   // response monitor: every done/err pulse must match the head of exp_q
   always @(negedge clk) begin
      if (!rst && (done_a || done_b || err_a || err_b)) begin
         if (exp_q.size() == 0) check_eq("resp_unexpected", 64'({done_a, done_b, err_a, err_b}), 64'd0);
         else begin
            logic [DATA_W+3:0] e;
            e = exp_q.pop_front();
            check_eq("resp_kind", 64'({done_a, done_b, err_a, err_b}), 64'(e[DATA_W+3:DATA_W]));
            check_eq("resp_rdata", 64'(rdata), 64'(e[DATA_W-1:0]));
         end
      end
   end

   task automatic push_txn(input logic b, input logic [DATA_W-1:0] addr, input logic we,
                           input logic [DATA_W-1:0] wdata, input logic timed_out);
      logic [3:0] kind;
      grant_q.push_back({b, b & we, addr, wdata});
      if (timed_out) kind = b ? 4'b0001 : 4'b0010;
      else begin
         kind        = b ? 4'b0100 : 4'b1000;
         model_rdata = resp_data;
      end
      exp_q.push_back({kind, model_rdata});
   endtask

   // waits for n done/err pulses, checks their timing, then drops both requests (RESP cycle)
   task automatic run_phase(input int n, input int first_lat, input int gap);
      int cyc, got, last;
      cyc = 0; got = 0; last = 0;
      while (got < n && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (done_a || done_b || err_a || err_b) begin
            got++;
            if (got == 1) check_eq("first_latency", 64'(cyc), 64'(first_lat));
            else          check_eq("pulse_gap", 64'(cyc - last), 64'(gap));
            last = cyc;
         end
      end
      if (got < n) check_eq("phase_timeout", 64'(got), 64'(n));
      req_a = 1'b0;
      req_b = 1'b0;
   endtask

   task automatic single_txn(input logic b, input logic [DATA_W-1:0] addr, input logic we,
                             input logic [DATA_W-1:0] wdata, input int lat, input logic [DATA_W-1:0] data);
      @(negedge clk);
      ack_lat   = lat;
      resp_data = data;
      if (b) begin
         req_b = 1'b1; addr_b = addr; we_b = we; wdata_b = wdata;
      end else begin
         req_a = 1'b1; addr_a = addr;
      end
      push_txn(b, addr, we, wdata, lat < 0);
      run_phase(1, lat < 0 ? TIMEOUT_CYC + 1 : lat + 2, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we_b = 1'b0;
      addr_a = '0; addr_b = '0; wdata_b = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      single_txn(1'b0, 32'h0000_0040, 1'b0, 32'h0, 1, 32'h0050_0093);
      single_txn(1'b1, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 0, 32'h1234_5678);
      single_txn(1'b0, 32'h0000_0080, 1'b0, 32'h0, -1, 32'hFFFF_FFFF);
      single_txn(1'b1, 32'h0000_0104, 1'b0, 32'h0, -1, 32'hFFFF_FFFF);

      for (int i = 0; i < 6; i++) begin
         logic              b, we;
         logic [DATA_W-1:0] addr, wdata, data;
         int                lat;
         b     = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         addr  = $urandom & 32'hFFFF_FFFC;
         wdata = $urandom;
         data  = $urandom;
         lat   = $urandom_range(0, 5);
         single_txn(b, addr, we, wdata, lat, data);
      end

      // reset while B is waiting on memory: no pulse, everything cleared, stray acks ignored
      @(negedge clk);
      ack_lat = -1;
      req_b = 1'b1; addr_b = 32'h0000_0400; we_b = 1'b1; wdata_b = 32'hCAFE_F00D;
      grant_q.push_back({1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D});
      for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
      check_eq("midop_granted", 64'(mem_req), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1; req_b = 1'b0; we_b = 1'b0;
      @(negedge clk);
      check_zero("midop_reset");
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      stray_ack = 1'b1; stray_data = 32'hBAD0_BAD0;
      repeat (3) begin
         @(negedge clk);
         check_eq("stray_ack_idle", 64'({busy, mem_req}), 64'd0);
         check_eq("stray_ack_rdata", 64'(rdata), 64'd0);
      end
      stray_ack = 1'b0;

      // contention straight after reset: last grant starts as B
      @(negedge clk);
      ack_lat = 0; resp_data = 32'h0F0F_1234;
      req_a = 1'b1; addr_a = 32'h0000_0200;
      req_b = 1'b1; addr_b = 32'h0000_0300; we_b = 1'b0; wdata_b = 32'h0;
      for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (i % 2 == 0) push_txn(1'b0, 32'h0000_0200, 1'b0, 32'h0, 1'b0);
         else            push_txn(1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
`else
         push_txn(1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
`endif
      end
      run_phase(4, 2, 3);

      repeat (4) @(negedge clk);
      check_eq("grant_q_empty", 64'(grant_q.size()), 64'd0);
      check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
      check_eq("final_idle", 64'(busy), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
